// File: rtl/control_sequencer.sv
// Hardwired control unit: steps T0..T7 per instruction and decodes datapath strobes
// from the current step and the opcode captured when fetch finishes.
module control_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [3:0]  ALUop,
  output logic        Run,
  output logic [3:0]  Present_state
);

  typedef enum logic [3:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    T7   = 4'd7,
    HALT = 4'd15
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state;
  state_t     done_state;
  logic [4:0] opcode;
  logic       unused_ir_bits;

  assign unused_ir_bits = ^IR[26:0];
  assign Present_state  = state;
  assign Run            = Reset | (state != HALT);

  // Every "return to T0" is diverted to HALT if a stop is pending on that edge.
  always_comb begin
    done_state = T0;
    if (Stop) done_state = HALT;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= T0;
      opcode <= OP_LD;
    end else begin
      unique case (state)
        T0: state <= T1;
        T1: state <= T2;
        T2: begin
          opcode <= IR[31:27];
          if (IR[31:27] == OP_HALT)
            state <= HALT;
          else if (IR[31:27] inside {OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB,
                                     OP_AND, OP_OR, OP_ADDI, OP_BR})
            state <= T3;
          else
            state <= done_state;
        end
        T3: state <= T4;
        T4: state <= T5;
        T5: state <= (opcode inside {OP_LD, OP_ST, OP_BR}) ? T6 : done_state;
        T6: state <= (opcode inside {OP_LD, OP_ST}) ? T7 : done_state;
        T7: state <= done_state;
        default: state <= HALT;
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0; MARin = 1'b0;
    Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; IncPC = 1'b0;
    Read = 1'b0; Write = 1'b0; CONin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
    ALUop = 4'b0011;
    if (!Reset) begin
      unique case (state)
        T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
        T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
        T2: begin MDRout = 1'b1; IRin = 1'b1; end
        T3: begin
          if (opcode inside {OP_LD, OP_LDI, OP_ST}) begin
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
          end else if (opcode == OP_BR) begin
            Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
          end else begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
        end
        T4: begin
          if (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = opcode[3:0];
          end else if (opcode == OP_BR) begin
            PCout = 1'b1; Yin = 1'b1;
          end else begin
            Cout = 1'b1; Zin = 1'b1;
          end
        end
        T5: begin
          if (opcode inside {OP_LD, OP_ST}) begin
            Zlowout = 1'b1; MARin = 1'b1;
          end else if (opcode == OP_BR) begin
            Cout = 1'b1; Zin = 1'b1;
          end else begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
        end
        T6: begin
          // A branch only reloads PC when the condition holds during this step.
          if (opcode == OP_LD) begin
            Read = 1'b1; MDRin = 1'b1;
          end else if (opcode == OP_ST) begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          end else if (CON) begin
            Zlowout = 1'b1; PCin = 1'b1;
          end
        end
        T7: begin
          if (opcode == OP_LD) begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else begin
            Write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios with literal expectations, then
// randomized instruction streams checked every cycle against a step/length model.
module tb_control_sequencer;

  logic        Clock;
  logic        Reset;
  logic [31:0] IR;
  logic        CON;
  logic        Stop;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC;
  logic Read, Write, CONin, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic [3:0] ALUop;
  logic       Run;
  logic [3:0] Present_state;

  int tests = 0;
  int fails = 0;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .CONin(CONin), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .ALUop(ALUop), .Run(Run), .Present_state(Present_state)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [20:0] dut_strobes;
  assign dut_strobes = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                        Yin, IncPC, Read, Write, CONin, Gra, Grb, Grc, Rin, Rout, BAout, Cout};

  localparam logic [20:0] M_PCOUT = 21'd1 << 20, M_ZLOW = 21'd1 << 19, M_MDROUT = 21'd1 << 17;
  localparam logic [20:0] M_MARIN = 21'd1 << 16, M_ZIN = 21'd1 << 15, M_PCIN = 21'd1 << 14;
  localparam logic [20:0] M_MDRIN = 21'd1 << 13, M_IRIN = 21'd1 << 12, M_YIN = 21'd1 << 11;
  localparam logic [20:0] M_INCPC = 21'd1 << 10, M_READ = 21'd1 << 9, M_WRITE = 21'd1 << 8;
  localparam logic [20:0] M_CONIN = 21'd1 << 7, M_GRA = 21'd1 << 6, M_GRB = 21'd1 << 5;
  localparam logic [20:0] M_GRC = 21'd1 << 4, M_RIN = 21'd1 << 3, M_ROUT = 21'd1 << 2;
  localparam logic [20:0] M_BAOUT = 21'd1 << 1, M_COUT = 21'd1;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011;
  localparam logic [4:0] SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110, ADDI = 5'b01100;
  localparam logic [4:0] BR = 5'b10010, NOP = 5'b11010, HALTOP = 5'b11011;

  // Instruction length in clock cycles, fetch included.
  function automatic int instr_len(input logic [4:0] op);
    if (op == LD || op == ST) return 8;
    if (op == BR) return 7;
    if (op inside {LDI, ADD, SUB, AND_, OR_, ADDI}) return 6;
    return 3;
  endfunction

  function automatic logic [20:0] exp_mask(input logic [4:0] op, input int step, input logic con);
    logic [20:0] m;
    m = '0;
    if (step == 0) m = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    else if (step == 1) m = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
    else if (step == 2) m = M_MDROUT | M_IRIN;
    else if (op inside {LD, LDI, ST}) begin
      if (step == 3) m = M_GRB | M_BAOUT | M_YIN;
      if (step == 4) m = M_COUT | M_ZIN;
      if (step == 5) m = (op == LDI) ? (M_ZLOW | M_GRA | M_RIN) : (M_ZLOW | M_MARIN);
      if (step == 6) m = (op == LD) ? (M_READ | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
      if (step == 7) m = (op == LD) ? (M_MDROUT | M_GRA | M_RIN) : M_WRITE;
    end else if (op == BR) begin
      if (step == 3) m = M_GRA | M_ROUT | M_CONIN;
      if (step == 4) m = M_PCOUT | M_YIN;
      if (step == 5) m = M_COUT | M_ZIN;
      if (step == 6 && con) m = M_ZLOW | M_PCIN;
    end else begin
      if (step == 3) m = M_GRB | M_ROUT | M_YIN;
      if (step == 4) m = (op == ADDI) ? (M_COUT | M_ZIN) : (M_GRC | M_ROUT | M_ZIN);
      if (step == 5) m = M_ZLOW | M_GRA | M_RIN;
    end
    return m;
  endfunction

  // Model: cycle index within the current instruction, or halted.
  int         m_step = 0;
  logic       m_halt = 1'b0;
  logic       m_valid = 1'b0;
  logic [4:0] m_op = LD;

  always @(posedge Clock) begin
    if (Reset) begin
      m_step = 0; m_halt = 1'b0; m_valid = 1'b1;
    end else if (m_valid && !m_halt) begin
      if (m_step == 2) m_op = IR[31:27];
      if (m_step == 2 && m_op == HALTOP) m_halt = 1'b1;
      else if (m_step == instr_len(m_op) - 1) begin
        if (Stop) m_halt = 1'b1;
        else m_step = 0;
      end else m_step = m_step + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (m_valid) begin
      logic [20:0] es;
      logic [3:0]  ea;
      es = (Reset || m_halt) ? 21'd0 : exp_mask(m_op, m_step, CON);
      ea = 4'b0011;
      if (!Reset && !m_halt && m_step == 4 && m_op inside {ADD, SUB, AND_, OR_}) ea = m_op[3:0];
      checkOutput("model_strobes", 32'(dut_strobes), 32'(es));
      checkOutput("model_aluop", 32'(ALUop), 32'(ea));
      checkOutput("model_run", 32'(Run), 32'(Reset || !m_halt));
      checkOutput("model_state", 32'(Present_state), m_halt ? 32'd15 : 32'(m_step));
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic c, input logic [31:0] ir);
    Reset = r; Stop = s; CON = c; IR = ir;
  endtask

  task automatic stepCycle();
    @(posedge Clock);
    #2;
  endtask

  task automatic doReset(input logic [31:0] ir, input logic c);
    applyStimulus(1'b1, 1'b0, c, ir);
    stepCycle();
    Reset = 1'b0;
  endtask

  logic [4:0] ops [14];
  int halted_for;

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // ldi sequence and its T5 strobes
    doReset(32'h0888_0000, 1'b0);
    for (int i = 0; i < 7; i++) begin
      int exp_states [7] = '{0, 1, 2, 3, 4, 5, 0};
      @(negedge Clock);
      checkOutput("ldi_state", 32'(Present_state), 32'(exp_states[i]));
      if (i == 0) checkOutput("ldi_t0_fetch", 32'(dut_strobes), 32'h11_8400);
      if (i == 5) checkOutput("ldi_t5_strobes", 32'(dut_strobes), 32'h08_0048);
      stepCycle();
    end

    // ld: Read/MDRin only in T1 and T6
    doReset(32'h0000_0000, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge Clock);
      checkOutput("ld_state", 32'(Present_state), (i == 8) ? 32'd0 : 32'(i));
      checkOutput("ld_read_mdrin", 32'({Read, MDRin}), (i == 1 || i == 6) ? 32'd3 : 32'd0);
      if (i == 7) checkOutput("ld_t7", 32'({MDRout, Gra, Rin}), 32'd7);
      stepCycle();
    end

    // sub: ALUop 0100 only in T4
    doReset(32'h2000_0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      checkOutput("sub_aluop", 32'(ALUop), (i == 4) ? 32'h4 : 32'h3);
      stepCycle();
    end

    // br, condition false then true
    for (int k = 0; k < 2; k++) begin
      doReset(32'h9000_0000, k[0]);
      for (int i = 0; i < 7; i++) begin
        @(negedge Clock);
        if (i == 6) checkOutput("br_t6", 32'(dut_strobes), (k == 0) ? 32'h0 : 32'h08_4000);
        stepCycle();
      end
      @(negedge Clock);
      checkOutput("br_back_to_t0", 32'(Present_state), 32'd0);
    end

    // Stop raised in T4 of ldi: finishes then halts until reset
    doReset(32'h0888_0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) Stop = 1'b1;
      @(negedge Clock);
      checkOutput("stop_state", 32'(Present_state), 32'(i));
      stepCycle();
    end
    Stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      checkOutput("halt_state", 32'(Present_state), 32'd15);
      checkOutput("halt_run", 32'(Run), 32'd0);
      stepCycle();
    end
    Reset = 1'b1;
    @(negedge Clock);
    checkOutput("reset_in_halt_run", 32'(Run), 32'd1);
    stepCycle();
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("post_halt_state", 32'(Present_state), 32'd0);
    checkOutput("post_halt_run", 32'(Run), 32'd1);
    stepCycle();

    // st interrupted by reset in T6: no Write ever
    doReset(32'h1000_0000, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) Reset = 1'b1;
      @(negedge Clock);
      checkOutput("st_state", 32'(Present_state), 32'(i));
      checkOutput("st_no_write", 32'(Write), 32'd0);
      stepCycle();
    end
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("st_reset_state", 32'(Present_state), 32'd0);
    checkOutput("st_reset_no_write", 32'(Write), 32'd0);
    stepCycle();

    // Random instruction streams, including undefined opcodes, halts and stops
    ops = '{LD, LDI, ST, ADD, SUB, AND_, OR_, ADDI, BR, NOP, HALTOP, 5'b00111, 5'b11111, 5'b10000};
    halted_for = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ir;
      logic        r;
      halted_for = m_halt ? halted_for + 1 : 0;
      r = (halted_for > 6) || ($urandom % 50 == 0);
      ir = IR;
      if (!m_halt && m_step == 0) ir = $urandom;
      else if (!m_halt && m_step == 1) ir = {ops[$urandom % 14], 27'($urandom)};
      applyStimulus(r, ($urandom % 12) == 0, 1'($urandom), ir);
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1: sole clock; all state changes on rising edge.
REQ-002 SHALL have port Reset, input, 1: synchronous, active-high.
REQ-003 SHALL have port IR, input, 32: instruction register; opcode = IR[31:27].
REQ-004 SHALL have port CON, input, 1: branch-condition flag from datapath CON logic.
REQ-005 SHALL have port Stop, input, 1: halt request.
REQ-006 SHALL have 1-bit outputs PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, Write, CONin, Gra, Grb, Grc, Rin, Rout, BAout, Cout: datapath control strobes.
REQ-007 SHALL have port ALUop, output, 4: ALU function select.
REQ-008 SHALL have port Run, output, 1: 1 while executing, 0 when halted.
REQ-009 SHALL have port Present_state, output, 4: T0..T7 = 0..7, HALT = 15.

Function
REQ-010 SHALL use a registered state with one state per clock; strobes SHALL be combinational decode of Present_state and opcode only.
REQ-011 SHALL deassert every strobe not listed for the current state; ALUop SHALL be 4'b0011 (ADD) unless specified.
REQ-012 Fetch SHALL be: T0 PCout,MARin,IncPC,Zin; T1 Zlowout,PCin,Read,MDRin; T2 MDRout,IRin.
REQ-013 Opcodes SHALL be: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, br 10010, nop 11010, halt 11011.
REQ-014 ld SHALL be: T3 Grb,BAout,Yin; T4 Cout,Zin; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin; then T0.
REQ-015 ldi SHALL be: T3 Grb,BAout,Yin; T4 Cout,Zin; T5 Zlowout,Gra,Rin; then T0.
REQ-016 st SHALL be: T3-T5 as ld; T6 Gra,Rout,MDRin (Read=0); T7 Write; then T0.
REQ-017 add/sub/and/or SHALL be: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin, ALUop = opcode[3:0]; T5 Zlowout,Gra,Rin; then T0.
REQ-018 addi SHALL be: T3 Grb,Rout,Yin; T4 Cout,Zin; T5 Zlowout,Gra,Rin; then T0.
REQ-019 br SHALL be: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin; T6 Zlowout and PCin only if CON=1 in T6, else no strobes; then T0.
REQ-020 nop and every undefined opcode SHALL go T2 -> T0 with no execute strobes.
REQ-021 halt SHALL go T2 -> HALT.
REQ-022 Any transition whose target is T0 SHALL instead go to HALT when Stop=1 on that edge; Stop SHALL have no effect mid-instruction.
REQ-023 HALT SHALL assert no strobes, hold Run=0, and be left only by Reset.
REQ-024 Run SHALL be 1 in T0..T7.
REQ-025 Opcode SHALL be sampled from IR only in T3..T7 and at the T2 edge; IR changes in T0-T2 SHALL not affect fetch strobes.

Reset
REQ-026 Reset=1 on an edge SHALL force Present_state=T0 on that edge from any state, including mid-instruction and HALT.
REQ-027 While Reset=1, all strobes SHALL be 0, ALUop=0011, Run=1.
REQ-028 After Reset falls, first state SHALL be T0 with fetch strobes per REQ-012.

Verification
REQ-029 Reset, IR=0x08880000 (ldi), Stop=0 -> states 0,1,2,3,4,5,0; T5 shows Zlowout=Gra=Rin=1; no other strobes in T5.
REQ-030 IR opcode ld -> 8-cycle instruction; Read=MDRin=1 exactly in T1 and T6; MDRout=Gra=Rin=1 in T7.
REQ-031 IR opcode sub (00100) -> ALUop=0100 in T4 only; ALUop=0011 in all other states.
REQ-032 br with CON=0 -> T6 all strobes 0; repeat with CON=1 -> T6 Zlowout=PCin=1.
REQ-033 Stop=1 raised in T4 of ldi -> completes T5, enters HALT (15), Run=0, stays 10 cycles; Reset -> T0, Run=1.
REQ-034 Reset asserted in T6 of st -> next state T0, Write never asserted.
